vram_port_a_arbiter: RTL and testbench

- Shares VRAM port A (address MA, write data, write enable, read data) among up to NUM_CLIENTS VDC-internal requesters: BG fetch, sprite fetch, VRAM-VRAM DMA and SATB DMA.
- Fixed priority, with starvation promotion so low-priority DMA clients always make progress.
- Registers every command before it reaches the VRAM and routes read data back to the issuing client with a tagged valid.
- Sits between the HuC6270 fetch/DMA engines and the dual-port VRAM. Port B (CPU) is outside this block.

---
 rtl/huc6270_vram_pkg.sv | 32 +++
 rtl/vram_port_a_arbiter_if.sv | 32 +++
 rtl/vram_prio_pick.sv | 26 ++
 rtl/vram_port_a_arbiter.sv | 159 +++++++++++++++
 tb/tb_vram_port_a_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/huc6270_vram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : huc6270_vram_pkg
// Brief    : Shared VRAM port A widths, command/tag types and address helper.
// Revision : 1.0 - initial release
// ============================================================================
package huc6270_vram_pkg;

    localparam int VRAM_ADDR_W  = 16;
    localparam int VRAM_DATA_W  = 16;
    localparam logic [VRAM_ADDR_W-1:0] VRAM_WORDS = 16'h8000;
    localparam int CLIENT_IDX_W = 4;

    typedef struct packed {
        logic                   we;
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] wdata;
    } vram_cmd_t;

    typedef struct packed {
        logic                    valid;
        logic [CLIENT_IDX_W-1:0] client;
        logic                    oob;
    } vram_tag_t;

    // Addresses beyond the physical 32K words are granted but never touch VRAM.
    function automatic logic addr_is_oob(input logic [VRAM_ADDR_W-1:0] addr);
        return addr >= VRAM_WORDS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_port_a_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_port_a_arbiter_if
// Brief    : Client request/grant/return bus plus VRAM port A signals.
// Revision : 1.0 - initial release
// ============================================================================
interface vram_port_a_arbiter_if #(
    parameter int NUM_CLIENTS = 4
);
    logic [NUM_CLIENTS-1:0]                                  req;
    logic [NUM_CLIENTS-1:0]                                  we;
    logic [NUM_CLIENTS-1:0][huc6270_vram_pkg::VRAM_ADDR_W-1:0] addr;
    logic [NUM_CLIENTS-1:0][huc6270_vram_pkg::VRAM_DATA_W-1:0] wdata;
    logic [NUM_CLIENTS-1:0]                                  gnt;
    logic [NUM_CLIENTS-1:0]                                  rvalid;
    logic [huc6270_vram_pkg::VRAM_DATA_W-1:0]                rdata;
    logic [huc6270_vram_pkg::VRAM_ADDR_W-1:0]                vram_ma;
    logic [huc6270_vram_pkg::VRAM_DATA_W-1:0]                vram_md_wr;
    logic                                                    vram_we;
    logic [huc6270_vram_pkg::VRAM_DATA_W-1:0]                vram_md_rd;

    modport master (
        input  req, we, addr, wdata, vram_md_rd,
        output gnt, rvalid, rdata, vram_ma, vram_md_wr, vram_we
    );

    modport slave (
        output req, we, addr, wdata, vram_md_rd,
        input  gnt, rvalid, rdata, vram_ma, vram_md_wr, vram_we
    );
endinterface
`default_nettype wire

// File: rtl/vram_prio_pick.sv
`default_nettype none
// ============================================================================
// Module   : vram_prio_pick
// Brief    : Lowest-index pick from the promoted set, else the eligible set.
// Revision : 1.0 - initial release
// ============================================================================
module vram_prio_pick #(
    parameter int NUM_CLIENTS = 4
) (
    input  wire  [NUM_CLIENTS-1:0] i_promoted,
    input  wire  [NUM_CLIENTS-1:0] i_eligible,
    output logic [NUM_CLIENTS-1:0] o_winner,
    output logic                   o_valid
);

    logic [NUM_CLIENTS-1:0] w_pool;

    // x & -x isolates the lowest set bit, giving a one-hot winner.
    always_comb begin
        w_pool   = (|i_promoted) ? i_promoted : i_eligible;
        o_winner = w_pool & (~w_pool + NUM_CLIENTS'(1));
        o_valid  = |w_pool;
    end

endmodule
`default_nettype wire

// File: rtl/vram_port_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_port_a_arbiter
// Brief    : Fixed-priority VRAM port A arbiter with starvation promotion and
//            tagged read return. Define VRAM_ARB_STATS_EN for grant/conflict
//            statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module vram_port_a_arbiter
    import huc6270_vram_pkg::*;
#(
    parameter int NUM_CLIENTS  = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int RD_LATENCY   = 1
) (
    input  wire  clock,
    input  wire  reset_N,
`ifdef VRAM_ARB_STATS_EN
    input  wire  stats_clr,
    output logic [NUM_CLIENTS-1:0][15:0] grant_cnt,
    output logic [15:0]                  conflict_cnt,
`endif
    vram_port_a_arbiter_if.master bus
);

    localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);

    logic [NUM_CLIENTS-1:0]      w_elig;
    logic [NUM_CLIENTS-1:0]      w_prom;
    logic [NUM_CLIENTS-1:0]      w_win;
    logic                        w_win_vld;
    logic [CLIENT_IDX_W-1:0]     w_win_idx;
    vram_cmd_t                   w_cmd;
    logic                        w_oob;
    vram_tag_t                   w_ret;

    logic [NUM_CLIENTS-1:0]      r_gnt;
    logic [NUM_CLIENTS-1:0][7:0] r_wait;
    logic [VRAM_ADDR_W-1:0]      r_ma;
    logic [VRAM_DATA_W-1:0]      r_md_wr;
    logic                        r_we;
    vram_tag_t [RD_LATENCY:0]    r_tag;

    // A client shown gnt this cycle is masked so its held req is not re-granted.
    assign w_elig = bus.req & ~r_gnt;

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_prom[i] = w_elig[i] && (r_wait[i] == c_STARVE_LIMIT);
        end
    end

    vram_prio_pick #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_pick (
        .i_promoted (w_prom),
        .i_eligible (w_elig),
        .o_winner   (w_win),
        .o_valid    (w_win_vld)
    );

    always_comb begin
        w_win_idx = '0;
        w_cmd     = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_win[i]) begin
                w_win_idx = CLIENT_IDX_W'(i);
                w_cmd     = '{we: bus.we[i], addr: bus.addr[i], wdata: bus.wdata[i]};
            end
        end
        w_oob = addr_is_oob(w_cmd.addr);
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            r_gnt   <= '0;
            r_we    <= 1'b0;
            r_ma    <= '0;
            r_md_wr <= '0;
        end else begin
            r_gnt <= w_win;
            r_we  <= w_win_vld & w_cmd.we & ~w_oob;
            if (w_win_vld) begin
                r_ma    <= w_cmd.addr;
                r_md_wr <= w_cmd.wdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            r_wait <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (!bus.req[i] || w_win[i]) begin
                    r_wait[i] <= 8'd0;
                end else if (w_elig[i] && (r_wait[i] != c_STARVE_LIMIT)) begin
                    r_wait[i] <= r_wait[i] + 8'd1;
                end
            end
        end
    end

    // Read tags ride alongside the VRAM access so data returns to its issuer.
    always_ff @(posedge clock) begin
        if (!reset_N) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= '{valid: w_win_vld & ~w_cmd.we, client: w_win_idx, oob: w_oob};
            for (int k = 1; k <= RD_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_ret = r_tag[RD_LATENCY];

    always_comb begin
        bus.rvalid = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            bus.rvalid[i] = w_ret.valid && (w_ret.client == CLIENT_IDX_W'(i));
        end
        bus.rdata = (w_ret.valid && !w_ret.oob) ? bus.vram_md_rd : '0;
    end

    assign bus.gnt        = r_gnt;
    assign bus.vram_ma    = r_ma;
    assign bus.vram_md_wr = r_md_wr;
    assign bus.vram_we    = r_we;

`ifdef VRAM_ARB_STATS_EN
    logic [NUM_CLIENTS-1:0][15:0] r_grant_cnt;
    logic [15:0]                  r_conflict_cnt;
    logic                         w_multi;

    assign w_multi = (w_elig & (w_elig - NUM_CLIENTS'(1))) != '0;

    always_ff @(posedge clock) begin
        if (!reset_N || stats_clr) begin
            r_grant_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (w_win[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
            if (w_multi && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign grant_cnt    = r_grant_cnt;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_port_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_port_a_arbiter
// Brief    : Scoreboard bench: queued client commands, reference arbitration
//            model, behavioural VRAM and a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_port_a_arbiter;
    import huc6270_vram_pkg::*;

    localparam int NC    = 4;
    localparam int LIMIT = 8;
    localparam int LAT   = 1;

    typedef struct {
        int          cyc;
        logic [NC-1:0] gnt;
        logic        we;
        logic [15:0] ma;
        logic [15:0] wd;
        bit          rst;
    } exp_t;

    typedef struct {
        int          due;
        int          client;
        logic [15:0] data;
    } rd_t;

    logic clock   = 1'b0;
    logic reset_N = 1'b0;
    logic preload = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   rst_drv = 1'b1;
    bit   rand_en = 1'b0;

    exp_t        expq[$];
    rd_t         rq[$];
    vram_cmd_t   cq[NC][$];
    logic [15:0] gold [32768];
    logic [15:0] vram [32768];
    int          m_wait [NC];
    logic [NC-1:0] m_gnt = '0;
    logic [15:0] m_ma  = '0;
    logic [15:0] m_wd  = '0;

    always #5 clock = ~clock;

    vram_port_a_arbiter_if #(.NUM_CLIENTS(NC)) bus ();

`ifdef VRAM_ARB_STATS_EN
    logic [NC-1:0][15:0] grant_cnt;
    logic [15:0]         conflict_cnt;
`endif

    vram_port_a_arbiter #(
        .NUM_CLIENTS  (NC),
        .STARVE_LIMIT (LIMIT),
        .RD_LATENCY   (LAT)
    ) dut (
        .clock        (clock),
        .reset_N      (reset_N),
`ifdef VRAM_ARB_STATS_EN
        .stats_clr    (1'b0),
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt),
`endif
        .bus          (bus)
    );

    function automatic logic [15:0] init_word(input int a);
        if (a == 'h0123) return 16'hBEEF;
        return 16'(a * 40503) ^ 16'h1234;
    endfunction

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000 | 16'($urandom_range(0, 15));
            2:       return 16'hC000;
            default: return 16'($urandom_range(0, 15));
        endcase
    endfunction

    // Synchronous single-port VRAM, one cycle read latency.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 32768; i++) vram[i] <= init_word(i);
        end else if (bus.vram_we) begin
            vram[bus.vram_ma[14:0]] <= bus.vram_md_wr;
        end
        bus.vram_md_rd <= vram[bus.vram_ma[14:0]];
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle grant/VRAM expectations and tagged read returns.
    always @(negedge clock) begin
        exp_t e;
        rd_t  r;
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            chk("gnt", 32'(bus.gnt), 32'(e.gnt));
            chk("vram_we", 32'(bus.vram_we), 32'(e.we));
            chk("vram_ma", 32'(bus.vram_ma), 32'(e.ma));
            chk("vram_md_wr", 32'(bus.vram_md_wr), 32'(e.wd));
            if (e.rst) begin
                chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
                chk("rst_rdata", 32'(bus.rdata), 32'd0);
            end
        end
        if (bus.rvalid != '0) begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                chk("rvalid", 32'(bus.rvalid), 32'(1) << r.client);
                chk("rdata", 32'(bus.rdata), 32'(r.data));
            end else begin
                chk("unexpected_rvalid", 32'(bus.rvalid), 32'd0);
            end
        end else if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            chk("missing_rvalid", 32'(bus.rvalid), 32'(1) << r.client);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (bus.gnt[i] === 1'b1 && cq[i].size() > 0) cq[i].delete(0);
        end
    endtask

    // Drive this cycle's inputs and predict the outputs of the next cycle.
    task automatic drive_predict();
        logic [NC-1:0] req;
        logic [NC-1:0] elig;
        int            w;
        vram_cmd_t     c;
        logic          wexp;
        if (rand_en) begin
            for (int i = 0; i < NC; i++) begin
                if (cq[i].size() < 2 && $urandom_range(0, 3) == 0)
                    cq[i].push_back('{we: 1'($urandom_range(0, 1)), addr: rand_addr(), wdata: 16'($urandom)});
            end
        end
        reset_N = ~rst_drv;
        for (int i = 0; i < NC; i++) begin
            if (cq[i].size() > 0) begin
                c             = cq[i][0];
                req[i]        = 1'b1;
                bus.req[i]    = 1'b1;
                bus.we[i]     = c.we;
                bus.addr[i]   = c.addr;
                bus.wdata[i]  = c.wdata;
            end else begin
                req[i]        = 1'b0;
                bus.req[i]    = 1'b0;
                bus.we[i]     = 1'($urandom);
                bus.addr[i]   = 16'($urandom);
                bus.wdata[i]  = 16'($urandom);
            end
        end
        if (rst_drv) begin
            m_gnt = '0;
            m_ma  = '0;
            m_wd  = '0;
            for (int i = 0; i < NC; i++) m_wait[i] = 0;
            while (rq.size() > 0 && rq[rq.size()-1].due > cyc) rq.delete(rq.size() - 1);
            expq.push_back('{cyc: cyc + 1, gnt: '0, we: 1'b0, ma: 16'h0, wd: 16'h0, rst: 1'b1});
            return;
        end
        elig = req & ~m_gnt;
        w = -1;
        for (int i = 0; i < NC; i++) if (w < 0 && elig[i] && m_wait[i] == LIMIT) w = i;
        for (int i = 0; i < NC; i++) if (w < 0 && elig[i]) w = i;
        for (int i = 0; i < NC; i++) begin
            if (!req[i] || i == w) m_wait[i] = 0;
            else if (elig[i] && m_wait[i] < LIMIT) m_wait[i]++;
        end
        m_gnt = '0;
        wexp  = 1'b0;
        if (w >= 0) begin
            c        = cq[w][0];
            m_gnt[w] = 1'b1;
            m_ma     = c.addr;
            m_wd     = c.wdata;
            wexp     = c.we && (c.addr < 16'h8000);
            if (wexp) gold[c.addr[14:0]] = c.wdata;
            if (!c.we)
                rq.push_back('{due: cyc + 1 + LAT, client: w,
                               data: (c.addr < 16'h8000) ? gold[c.addr[14:0]] : 16'h0000});
        end
        expq.push_back('{cyc: cyc + 1, gnt: m_gnt, we: wexp, ma: m_ma, wd: m_wd, rst: 1'b0});
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            drive_predict();
        end
    endtask

    function automatic int pending();
        int p;
        p = rq.size();
        for (int i = 0; i < NC; i++) p += cq[i].size();
        return p;
    endfunction

    initial begin
        for (int i = 0; i < 32768; i++) gold[i] = init_word(i);
        for (int i = 0; i < NC; i++) m_wait[i] = 0;
        rst_drv = 1'b1;
        preload = 1'b1;
        drive_predict();
        run(1);
        preload = 1'b0;
        run(3);
        rst_drv = 1'b0;
        run(2);

        // Single read of a known word.
        cq[2].push_back('{we: 1'b0, addr: 16'h0123, wdata: 16'h0});
        run(5);

        // Write to the last in-range word, then read it back.
        cq[1].push_back('{we: 1'b1, addr: 16'h7FFF, wdata: 16'h5A5A});
        cq[1].push_back('{we: 1'b0, addr: 16'h7FFF, wdata: 16'h0});
        run(6);

        // Out-of-range write is dropped, out-of-range read returns zero.
        cq[0].push_back('{we: 1'b1, addr: 16'h8000, wdata: 16'h1234});
        cq[0].push_back('{we: 1'b0, addr: 16'hC000, wdata: 16'h0});
        cq[0].push_back('{we: 1'b0, addr: 16'h0000, wdata: 16'h0});
        run(8);

        // Contention: 0 and 1 alternate until client 3 is promoted.
        for (int i = 0; i < 10; i++) begin
            cq[0].push_back('{we: 1'b0, addr: 16'(i), wdata: 16'h0});
            cq[1].push_back('{we: 1'b0, addr: 16'(i + 4), wdata: 16'h0});
        end
        cq[3].push_back('{we: 1'b0, addr: 16'h0123, wdata: 16'h0});
        run(30);

        // Back-to-back service of two continuously requesting clients.
        for (int i = 0; i < 6; i++) begin
            cq[0].push_back('{we: 1'b0, addr: 16'(i + 8), wdata: 16'h0});
            cq[2].push_back('{we: 1'b0, addr: 16'h7FFF, wdata: 16'h0});
        end
        run(16);

        // Reset while reads are in flight and client 3 has been waiting.
        for (int i = 0; i < 8; i++) begin
            cq[0].push_back('{we: 1'b0, addr: 16'(i), wdata: 16'h0});
            cq[1].push_back('{we: 1'b0, addr: 16'(i + 3), wdata: 16'h0});
        end
        cq[3].push_back('{we: 1'b0, addr: 16'h0002, wdata: 16'h0});
        run(5);
        rst_drv = 1'b1;
        run(3);
        rst_drv = 1'b0;
        run(30);

        // Randomized traffic on all clients.
        rand_en = 1'b1;
        run(400);
        rand_en = 1'b0;

        for (int t = 0; t < 200 && pending() > 0; t++) run(1);
        chk("drain_timeout", 32'(pending()), 32'd0);
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
